// File: rtl/gamecontrol_seq_if.sv
// Game controller bundle: login/timer/player/display signals.
// clk and rst stay plain ports on the modules that use this bundle.
interface gamecontrol_seq_if #(
    parameter int DIGIT_W      = 4,
    parameter int SCORE_DIGITS = 2
);
    logic                      logged_in;
    logic                      game_start;
    logic [DIGIT_W-1:0]        morse_number;
    logic                      show_done;
    logic                      load;
    logic [DIGIT_W-1:0]        user_input;
    logic                      timeout;
    logic                      logout;
    logic                      reconfig;
    logic                      enable;
    logic                      show_en;
    logic [DIGIT_W-1:0]        number;
    logic [2:0]                idx;
    logic [4*SCORE_DIGITS-1:0] score;
    logic [3:0]                misses;
    logic                      correct;
    logic                      round_done;
    logic                      game_over;
    logic                      logout_from_gamecontrol;

    modport master (
        input  logged_in, game_start, morse_number, show_done,
        input  load, user_input, timeout, logout,
        output reconfig, enable, show_en, number, idx, score,
        output misses, correct, round_done, game_over,
        output logout_from_gamecontrol
    );

    modport slave (
        output logged_in, game_start, morse_number, show_done,
        output load, user_input, timeout, logout,
        input  reconfig, enable, show_en, number, idx, score,
        input  misses, correct, round_done, game_over,
        input  logout_from_gamecontrol
    );
endinterface

// File: rtl/gamecontrol_seq.sv
// Morse sequence game controller: present SEQ_LEN digits, collect entries,
// keep a saturating BCD score and a miss count.
module gamecontrol_seq #(
    parameter int SEQ_LEN      = 3,
    parameter int DIGIT_W      = 4,
    parameter int SCORE_DIGITS = 2,
    parameter int MAX_MISSES   = 3
) (
    input  logic clk,
    input  logic rst,
    gamecontrol_seq_if.master gc
);
    localparam int SW = 4 * SCORE_DIGITS;
    localparam logic [2:0] LAST = 3'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RECONFIG, S_WAIT, S_PRESENT,
        S_HOLD, S_ENTRY, S_DECISION, S_GAMEOVER
    } state_e;

    state_e             state_q, state_d;
    logic [DIGIT_W-1:0] seq_q [8];
    logic [DIGIT_W-1:0] seq_d [8];
    logic               flag_q, flag_d;
    logic [2:0]         idx_q, idx_d;
    logic [DIGIT_W-1:0] number_q, number_d;
    logic [SW-1:0]      score_q, score_d;
    logic [3:0]         misses_q, misses_d;
    logic               correct_q, correct_d;
    logic               enable_q, enable_d;
    logic               show_en_q, show_en_d;
    logic               game_over_q, game_over_d;
    logic               reconfig_q, reconfig_d;
    logic               round_done_q, round_done_d;
    logic               ack_q, ack_d;
    logic               go_over, restart, wipe;

    // All-nines saturates; otherwise a decimal ripple increment.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic c, nines;
        r = s;
        c = 1'b1;
        nines = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++)
            if (s[4*i +: 4] != 4'd9) nines = 1'b0;
        if (!nines)
            for (int i = 0; i < SCORE_DIGITS; i++)
                if (c) begin
                    if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                    else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        flag_d       = flag_q;
        idx_d        = idx_q;
        number_d     = number_q;
        score_d      = score_q;
        misses_d     = misses_q;
        correct_d    = correct_q;
        enable_d     = enable_q;
        show_en_d    = show_en_q;
        game_over_d  = game_over_q;
        reconfig_d   = 1'b0;
        round_done_d = 1'b0;
        ack_d        = 1'b0;
        go_over      = 1'b0;
        restart      = 1'b0;
        wipe         = 1'b0;
        unique case (state_q)
            S_IDLE:     if (gc.logged_in) restart = 1'b1;
            S_RECONFIG: state_d = S_WAIT;
            S_WAIT:
                if (gc.game_start) begin
                    enable_d = 1'b1;
                    state_d  = S_PRESENT;
                end
            S_PRESENT:
                if (gc.timeout) go_over = 1'b1;
                else begin
                    seq_d[idx_q] = gc.morse_number;
                    number_d     = gc.morse_number;
                    show_en_d    = 1'b1;
                    state_d      = S_HOLD;
                end
            S_HOLD:
                if (gc.timeout) go_over = 1'b1;
                else if (gc.show_done) begin
                    show_en_d = 1'b0;
                    if (idx_q == LAST) begin
                        idx_d    = '0;
                        number_d = '1;
                        state_d  = S_ENTRY;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_PRESENT;
                    end
                end
            S_ENTRY:
                if (gc.timeout) go_over = 1'b1;
                else if (gc.load) begin
                    if (gc.user_input != seq_q[idx_q]) flag_d = 1'b0;
                    if (idx_q == LAST) state_d = S_DECISION;
                    else idx_d = idx_q + 3'd1;
                end
            S_DECISION: begin
                round_done_d = 1'b1;
                if (flag_q) begin
                    correct_d = 1'b1;
                    score_d   = bcd_inc(score_q);
                end else begin
                    correct_d = 1'b0;
                    misses_d  = misses_q + 4'd1;
                end
                // The round's result commits even when the game ends here.
                if (gc.timeout || (MAX_MISSES != 0 && !flag_q &&
                    misses_q + 4'd1 == 4'(MAX_MISSES)))
                    go_over = 1'b1;
                else begin
                    idx_d   = '0;
                    flag_d  = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_GAMEOVER: if (gc.game_start) restart = 1'b1;
            default:    wipe = 1'b1;
        endcase
        if (go_over) begin
            state_d     = S_GAMEOVER;
            enable_d    = 1'b0;
            show_en_d   = 1'b0;
            number_d    = '0;
            game_over_d = 1'b1;
        end
        if (restart) begin
            state_d     = S_RECONFIG;
            reconfig_d  = 1'b1;
            score_d     = '0;
            misses_d    = '0;
            correct_d   = 1'b0;
            idx_d       = '0;
            flag_d      = 1'b1;
            number_d    = '0;
            enable_d    = 1'b0;
            show_en_d   = 1'b0;
            game_over_d = 1'b0;
        end
        if (gc.logout && state_q != S_IDLE) begin
            wipe  = 1'b1;
            ack_d = 1'b1;
        end
        if (wipe) begin
            state_d      = S_IDLE;
            seq_d        = '{default: '0};
            flag_d       = 1'b1;
            idx_d        = '0;
            number_d     = '0;
            score_d      = '0;
            misses_d     = '0;
            correct_d    = 1'b0;
            enable_d     = 1'b0;
            show_en_d    = 1'b0;
            game_over_d  = 1'b0;
            reconfig_d   = 1'b0;
            round_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            seq_q        <= '{default: '0};
            flag_q       <= 1'b1;
            idx_q        <= '0;
            number_q     <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            correct_q    <= 1'b0;
            enable_q     <= 1'b0;
            show_en_q    <= 1'b0;
            game_over_q  <= 1'b0;
            reconfig_q   <= 1'b0;
            round_done_q <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            flag_q       <= flag_d;
            idx_q        <= idx_d;
            number_q     <= number_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            correct_q    <= correct_d;
            enable_q     <= enable_d;
            show_en_q    <= show_en_d;
            game_over_q  <= game_over_d;
            reconfig_q   <= reconfig_d;
            round_done_q <= round_done_d;
            ack_q        <= ack_d;
        end
    end

    assign gc.reconfig                = reconfig_q;
    assign gc.enable                  = enable_q;
    assign gc.show_en                 = show_en_q;
    assign gc.number                  = number_q;
    assign gc.idx                     = idx_q;
    assign gc.score                   = score_q;
    assign gc.misses                  = misses_q;
    assign gc.correct                 = correct_q;
    assign gc.round_done              = round_done_q;
    assign gc.game_over               = game_over_q;
    assign gc.logout_from_gamecontrol = ack_q;
endmodule

// File: tb/tb_gamecontrol_seq.sv
// Directed/randomized bench for gamecontrol_seq with a score/miss model
// kept as plain integers.
module tb_gamecontrol_seq;
    localparam int SL = 3;
    localparam int DW = 4;
    localparam int SD = 2;
    localparam int MM = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   wins, miss;
    int   dig [SL];
    int   ent [SL];

    gamecontrol_seq_if #(.DIGIT_W(DW), .SCORE_DIGITS(SD)) bif ();

    gamecontrol_seq #(
        .SEQ_LEN(SL), .DIGIT_W(DW), .SCORE_DIGITS(SD), .MAX_MISSES(MM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .gc (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bcd(input int n);
        int s;
        s = (n > 99) ? 99 : n;
        return 32'((s / 10) * 16 + s % 10);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_reconfig"}, 32'(bif.reconfig), 0);
        chk({tag, "_enable"}, 32'(bif.enable), 0);
        chk({tag, "_show_en"}, 32'(bif.show_en), 0);
        chk({tag, "_number"}, 32'(bif.number), 0);
        chk({tag, "_idx"}, 32'(bif.idx), 0);
        chk({tag, "_score"}, 32'(bif.score), 0);
        chk({tag, "_misses"}, 32'(bif.misses), 0);
        chk({tag, "_correct"}, 32'(bif.correct), 0);
        chk({tag, "_round_done"}, 32'(bif.round_done), 0);
        chk({tag, "_game_over"}, 32'(bif.game_over), 0);
        chk({tag, "_ack"}, 32'(bif.logout_from_gamecontrol), 0);
    endtask

    task automatic start_game(input bit enter);
        bif.game_start = 1'b1;
        if (enter) begin
            tick();
            chk("reconfig_pulse", 32'(bif.reconfig), 1);
            chk("reconfig_score", 32'(bif.score), 0);
            chk("reconfig_misses", 32'(bif.misses), 0);
            chk("reconfig_go", 32'(bif.game_over), 0);
        end
        tick();
        chk("reconfig_drop", 32'(bif.reconfig), 0);
        tick();
        chk("enable_on", 32'(bif.enable), 1);
        bif.game_start = 1'b0;
        wins = 0;
        miss = 0;
    endtask

    // mode 0: normal, 1: timeout with final load, 2: logout mid-entry
    task automatic play_round(input int mode);
        int  n;
        bit  win;
        for (int i = 0; i < SL; i++) begin
            bif.morse_number = DW'(dig[i]);
            n = 0;
            while (bif.show_en !== 1'b1 && n < 8) begin
                tick();
                n++;
            end
            chk("show_en_rise", 32'(bif.show_en), 1);
            chk("slot_number", 32'(bif.number), 32'(dig[i]));
            chk("slot_idx", 32'(bif.idx), 32'(i));
            if (i == 0) chk("round_done_low", 32'(bif.round_done), 0);
            bif.morse_number = (i < SL - 1) ? DW'(dig[i+1]) : DW'($urandom);
            repeat ($urandom_range(0, 2)) begin
                bif.load = 1'($urandom);
                bif.user_input = DW'($urandom);
                tick();
            end
            bif.load = 1'b0;
            bif.show_done = 1'b1;
            tick();
            bif.show_done = 1'b0;
            chk("show_en_gap", 32'(bif.show_en), 0);
        end
        chk("entry_prompt", 32'(bif.number), 32'hF);
        chk("entry_idx", 32'(bif.idx), 0);
        for (int i = 0; i < SL; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bif.user_input = DW'($urandom);
                tick();
            end
            if (mode == 2 && i == 1) begin
                bif.logout = 1'b1;
                tick();
                bif.logout = 1'b0;
                chk("logout_ack", 32'(bif.logout_from_gamecontrol), 1);
                chk("logout_score", 32'(bif.score), 0);
                chk("logout_number", 32'(bif.number), 0);
                chk("logout_enable", 32'(bif.enable), 0);
                tick();
                chk("logout_ack_drop", 32'(bif.logout_from_gamecontrol), 0);
                chk("relogin_reconfig", 32'(bif.reconfig), 1);
                return;
            end
            bif.load = 1'b1;
            bif.user_input = DW'(ent[i]);
            if (mode == 1 && i == SL - 1) bif.timeout = 1'b1;
            tick();
            bif.load = 1'b0;
            bif.timeout = 1'b0;
        end
        if (mode == 1) begin
            chk("to_game_over", 32'(bif.game_over), 1);
            chk("to_no_round_done", 32'(bif.round_done), 0);
            chk("to_enable", 32'(bif.enable), 0);
            chk("to_number", 32'(bif.number), 0);
            chk("to_score", 32'(bif.score), bcd(wins));
            return;
        end
        chk("decision_rd_early", 32'(bif.round_done), 0);
        tick();
        win = 1'b1;
        for (int i = 0; i < SL; i++) if (ent[i] != dig[i]) win = 1'b0;
        if (win) wins++;
        else miss++;
        chk("round_done", 32'(bif.round_done), 1);
        chk("correct", 32'(bif.correct), 32'(win));
        chk("score", 32'(bif.score), bcd(wins));
        chk("misses", 32'(bif.misses), 32'(miss));
        chk("game_over", 32'(bif.game_over), 32'(miss == MM));
        chk("enable", 32'(bif.enable), 32'(miss != MM));
    endtask

    task automatic rand_digits();
        for (int i = 0; i < SL; i++) begin
            dig[i] = int'($urandom_range(0, 9));
            ent[i] = dig[i];
        end
    endtask

    initial begin
        bif.logged_in = 1'b0;
        bif.game_start = 1'b0;
        bif.morse_number = '0;
        bif.show_done = 1'b0;
        bif.load = 1'b0;
        bif.user_input = '0;
        bif.timeout = 1'b0;
        bif.logout = 1'b0;
        rst = 1'b1;
        tick();
        outs_zero("reset");
        rst = 1'b0;
        tick();
        outs_zero("idle");
        bif.logged_in = 1'b1;
        start_game(1'b1);

        dig = '{5, 2, 7};
        ent = '{5, 2, 7};
        play_round(0);
        chk("first_score", 32'(bif.score), 32'h01);
        ent = '{5, 3, 7};
        play_round(0);
        play_round(0);
        chk("miss_over", 32'(bif.game_over), 1);
        chk("miss_score", 32'(bif.score), 32'h01);

        start_game(1'b1);
        for (int r = 0; r < 103; r++) begin
            rand_digits();
            if (r == 40) ent[1] = (dig[1] + 1) % 10;
            play_round(0);
            if (wins == 9 && r < 40) chk("score_09", 32'(bif.score), 32'h09);
            if (wins == 10 && r < 40) chk("score_10", 32'(bif.score), 32'h10);
            if (wins >= 99) chk("score_sat", 32'(bif.score), 32'h99);
        end

        rand_digits();
        play_round(1);
        start_game(1'b1);

        rand_digits();
        play_round(2);
        start_game(1'b0);
        bif.morse_number = 4'd4;
        tick();
        chk("hold_show_en", 32'(bif.show_en), 1);
        #2 rst = 1'b1;
        #1 outs_zero("async_rst");
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gamecontrol_seq.md
Name: gamecontrol_seq

Overview:
Parametrised successor to the three-digit Morse game controller. Presents a sequence of SEQ_LEN Morse digits, one per presentation slot, using a single show-timer handshake. It then collects and checks the same number of user entries, keeps a saturating BCD score, and ends the game on global timeout or after MAX_MISSES wrong rounds. It sits between the login FSM, the Morse ROM/player and the score display.

Parameters:
SEQ_LEN, 3, digits per round (1..8).
DIGIT_W, 4, width of a digit code. The all-ones code is reserved as the blank/prompt code.
SCORE_DIGITS, 2, number of BCD score digits (1..4).
MAX_MISSES, 3, wrong rounds before game over (0 = unlimited).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
logged_in  in  1  user authenticated (level)
game_start  in  1  start/restart request (level, sampled)
morse_number  in  DIGIT_W  current random digit from the generator
show_done  in  1  presentation slot finished (single-cycle pulse from the slot timer)
load  in  1  user entry strobe (single-cycle, pre-debounced)
user_input  in  DIGIT_W  user entry value
timeout  in  1  global game timer expired
logout  in  1  logout request
reconfig  out  1  one-cycle pulse requesting a timer/ROM reload
enable  out  1  game timer run enable
show_en  out  1  presentation slot timer enable
number  out  DIGIT_W  digit sent to the Morse player and display
idx  out  3  current slot index
score  out  4*SCORE_DIGITS  BCD score, least significant digit in [3:0]
misses  out  4  wrong rounds in the current game
correct  out  1  result of the last round (level)
round_done  out  1  one-cycle pulse per completed round
game_over  out  1  high in GAMEOVER
logout_from_gamecontrol  out  1  one-cycle logout acknowledge

Behaviour:
- Reset, asynchronous, dominates everything:
  - all outputs 0, state IDLE;
  - seq[] cleared, flag=1.
- Registered outputs only; every transition takes one clock.
- IDLE:
  - outputs held at reset values;
  - logged_in=1 -> RECONFIG.
- RECONFIG:
  - reconfig=1 for this cycle only;
  - score=0, misses=0, correct=0, idx=0, flag=1;
  - -> WAIT_START.
- WAIT_START: game_start=1 -> PRESENT, with enable=1 set in the same edge.
- PRESENT:
  - seq[idx]<=morse_number, number<=morse_number, show_en<=1;
  - -> HOLD.
- HOLD:
  - waits for show_done;
  - on show_done, show_en<=0;
  - if idx==SEQ_LEN-1: idx<=0, number<=all-ones, -> ENTRY;
  - else idx<=idx+1, -> PRESENT.
  - show_en therefore drops for exactly one cycle between slots.
- ENTRY:
  - on load, compare user_input with seq[idx] in the same cycle; mismatch clears flag;
  - if idx==SEQ_LEN-1 -> DECISION, else idx<=idx+1.
  - A load in any other state is ignored.
- DECISION:
  - round_done=1;
  - flag=1: correct<=1, score increments as a BCD ripple (digit 9 -> 0 with carry); at all-nines the score saturates and does not wrap;
  - flag=0: correct<=0, misses<=misses+1;
  - if MAX_MISSES!=0 and misses+1==MAX_MISSES -> GAMEOVER;
  - otherwise idx<=0, flag<=1, -> PRESENT.
- GAMEOVER:
  - enable=0, show_en=0, number=0, game_over=1;
  - score and misses are frozen;
  - game_start=1 -> RECONFIG.
- Timeout: timeout=1 in PRESENT, HOLD, ENTRY or DECISION -> GAMEOVER. It has priority over show_done, load and the DECISION transition.
  - If DECISION and timeout coincide, the score/miss update for that round still commits.
- Logout: logout=1 in any state except IDLE:
  - logout_from_gamecontrol=1 for one cycle;
  - all game registers cleared;
  - -> IDLE.
  - logout has priority over timeout and game_start.
- An all-ones morse_number is stored as-is; it will never match unless the user also enters all-ones.
- Illegal state encodings -> IDLE with reset values.

Test Plan:
- Reset mid-HOLD with show_en=1 -> all outputs 0 immediately (asynchronous), state IDLE, score 0.
- SEQ_LEN=3, digits 5,2,7, entries 5,2,7 -> show_en has 3 high periods, number=4'hF in ENTRY, round_done pulse, correct=1, score=8'h01.
- Entries 5,3,7 with MAX_MISSES=2 over two rounds -> misses=1 then 2, correct=0, game_over=1 after the second DECISION, score unchanged.
- Preload score 8'h09 then win a round -> 8'h10; from 8'h99 win -> stays 8'h99.
- timeout on the same cycle as load of the final entry -> GAMEOVER, no round_done; game_start -> reconfig pulse, score=0.
- logout during ENTRY -> logout_from_gamecontrol high for exactly 1 cycle, then IDLE; logged_in=1 -> RECONFIG.
